// File: rtl/tick_uart_tx.sv
// Tick-paced UART transmitter: start bit, DATA_W data bits LSB first, optional parity, STOP_BITS stop bits.
// Define PARITY_EN to add one parity bit per frame (polarity from PARITY_ODD).
module tick_uart_tx #(
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ARM    = 3'd1;
  localparam logic [2:0] START  = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] PARITY = 3'd4;
  localparam logic [2:0] STOP   = 3'd5;

  // Elaboration-time guards on the supported parameter ranges.
  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_width
    $error("tick_uart_tx: DATA_W must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("tick_uart_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity
    $error("tick_uart_tx: PARITY_ODD must be 0 or 1");
  end

  logic [2:0]        state_reg, state_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic              stop_reg, stop_next;
  logic              tx_reg, tx_next;
  logic              busy_reg, busy_next;
`ifdef PARITY_EN
  // Untouched copy of the accepted word; the shift register is consumed bit by bit.
  logic [DATA_W-1:0] word_reg, word_next;
`endif

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    idx_next   = idx_reg;
    stop_next  = stop_reg;
    tx_next    = tx_reg;
`ifdef PARITY_EN
    word_next  = word_reg;
`endif
    case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        if (in_valid) begin
          shift_next = in_data;
`ifdef PARITY_EN
          word_next  = in_data;
`endif
          state_next = ARM;
        end
      end
      ARM: begin
        if (tick) begin
          state_next = START;
          tx_next    = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_next = DATA;
          tx_next    = shift_reg[0];
          idx_next   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_reg == LAST_IDX) begin
`ifdef PARITY_EN
            state_next = PARITY;
            tx_next    = (^word_reg) ^ 1'(PARITY_ODD);
`else
            state_next = STOP;
            tx_next    = 1'b1;
            stop_next  = 1'b0;
`endif
          end else begin
            shift_next = shift_reg >> 1;
            tx_next    = shift_reg[1];
            idx_next   = idx_reg + 1'b1;
          end
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (tick) begin
          state_next = STOP;
          tx_next    = 1'b1;
          stop_next  = 1'b0;
        end
      end
`endif
      STOP: begin
        tx_next = 1'b1;
        if (tick) begin
          if (stop_reg == STOP_LAST) begin
            state_next = IDLE;
          end else begin
            stop_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      idx_reg   <= '0;
      stop_reg  <= 1'b0;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
`ifdef PARITY_EN
      word_reg  <= '0;
`endif
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      idx_reg   <= idx_next;
      stop_reg  <= stop_next;
      tx_reg    <= tx_next;
      busy_reg  <= busy_next;
`ifdef PARITY_EN
      word_reg  <= word_next;
`endif
    end
  end

  assign in_ready = (state_reg == IDLE);
  assign tx       = tx_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_tick_uart_tx.sv
// Bench for tick_uart_tx: two instances (8N1 and 8 data / 2 stop, odd) against a frame-queue model.
module tb_tick_uart_tx;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       tick;
  logic [1:0] valid;
  logic [7:0] data [2];
  logic [1:0] ready;
  logic [1:0] tx;
  logic [1:0] busy;

  tick_uart_tx #(.DATA_W(8), .STOP_BITS(1), .PARITY_ODD(0)) u0 (
    .clk(clk), .reset(reset), .tick(tick), .in_data(data[0]), .in_valid(valid[0]),
    .in_ready(ready[0]), .tx(tx[0]), .busy(busy[0]));

  tick_uart_tx #(.DATA_W(8), .STOP_BITS(2), .PARITY_ODD(1)) u1 (
    .clk(clk), .reset(reset), .tick(tick), .in_data(data[1]), .in_valid(valid[1]),
    .in_ready(ready[1]), .tx(tx[1]), .busy(busy[1]));

`ifdef PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int tick_period;
  int tcnt;
  logic tick_hold;
  logic chk_en;

  // Instance k has k+1 stop bits and parity polarity k.
  function automatic logic [15:0] frame_of(input logic [7:0] d, input int k);
    logic [15:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    if (PBITS == 1) f[9] = (^d) ^ (k == 1);
    return f;
  endfunction

  function automatic int frame_len(input int k);
    return 9 + PBITS + (k + 1);
  endfunction

  // Model: a frame is a list of line levels; each tick after acceptance emits the next one.
  logic        m_act [2];
  logic        m_tx  [2];
  int          m_pos [2];
  int          m_len [2];
  logic [15:0] m_frm [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_act[k] <= 1'b0;
        m_tx[k]  <= 1'b1;
        m_pos[k] <= 0;
      end else if (!m_act[k]) begin
        if (valid[k]) begin
          m_frm[k] <= frame_of(data[k], k);
          m_len[k] <= frame_len(k);
          m_pos[k] <= 0;
          m_act[k] <= 1'b1;
        end
      end else if (tick) begin
        if (m_pos[k] == m_len[k]) begin
          m_act[k] <= 1'b0;
          m_tx[k]  <= 1'b1;
        end else begin
          m_tx[k]  <= m_frm[k][m_pos[k]];
          m_pos[k] <= m_pos[k] + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input int k, input logic got, input logic want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s[%0d] t=%0t: got %b want %b", name, k, $time, got, want);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %0d want %0d", name, $time, got, want);
    end
  endtask

  // One cycle: compare outputs against the model, then drive the next tick level.
  task automatic cyc();
    @(negedge clk);
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk("tx", k, tx[k], m_tx[k]);
        chk("busy", k, busy[k], m_act[k]);
        chk("in_ready", k, ready[k], !m_act[k]);
      end
    end
    if (tick_hold) begin
      tick = 1'b1;
    end else if (tcnt >= tick_period - 1) begin
      tick = 1'b1;
      tcnt = 0;
    end else begin
      tick = 1'b0;
      tcnt++;
    end
  endtask

  logic [10:0] exp0;
  int nb0;
  int w, lows1, bf0, bf1;

  initial begin
    reset = 1'b1; tick = 1'b0; valid = '0; data[0] = '0; data[1] = '0;
    tick_period = 5; tick_hold = 1'b0; tcnt = 0; chk_en = 1'b0;
    repeat (3) cyc();
    chk_en = 1'b1;
    cyc();
    for (int k = 0; k < 2; k++) begin
      chk("rst_tx", k, tx[k], 1'b1);
      chk("rst_busy", k, busy[k], 1'b0);
      chk("rst_ready", k, ready[k], 1'b1);
    end
    reset = 1'b0;
    cyc();

    // Directed: 0xA5 on the 8N1 instance, 0x00 on the 2-stop instance, tick period 5.
    if (PBITS == 1) begin exp0 = 11'b10100101010; nb0 = 11; end
    else            begin exp0 = 11'b01101001010; nb0 = 10; end
    data[0] = 8'hA5; data[1] = 8'h00; valid = 2'b11;
    cyc();
    valid = 2'b00; data[0] = 8'h5A; data[1] = 8'hFF;
    w = 0;
    while (tx[0] !== 1'b0 && w < 40) begin cyc(); w++; end
    chk("start_seen", 0, (w < 40), 1'b1);
    lows1 = (tx[1] === 1'b0) ? 1 : 0;
    bf0 = -1; bf1 = -1;
    for (int idx = 1; idx <= 80; idx++) begin
      cyc();
      if (tx[1] === 1'b0) lows1++;
      if (busy[0] === 1'b0 && bf0 < 0) bf0 = idx;
      if (busy[1] === 1'b0 && bf1 < 0) bf1 = idx;
      if (idx >= 2 && (idx - 2) % 5 == 0 && (idx - 2) / 5 < nb0)
        chk("a5_bit", (idx - 2) / 5, tx[0], exp0[(idx - 2) / 5]);
    end
    chk_int("a5_busy_len", bf0, 5 * (9 + PBITS + 1));
    chk_int("zero_low_cycles", lows1, 45);
    chk_int("zero_busy_len", bf1, 5 * (9 + PBITS + 2));

    // Directed: reset during data bit 3 of a frame.
    data[0] = 8'h3C; valid[0] = 1'b1;
    cyc();
    valid[0] = 1'b0;
    w = 0;
    while (tx[0] !== 1'b0 && w < 40) begin cyc(); w++; end
    chk("start_seen2", 0, (w < 40), 1'b1);
    repeat (22) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("midrst_tx", 0, tx[0], 1'b1);
    chk("midrst_busy", 0, busy[0], 1'b0);
    chk("midrst_ready", 0, ready[0], 1'b1);

    // Randomized traffic across tick periods 1..7 plus tick held high.
    for (int seg = 0; seg < 8; seg++) begin
      tick_period = 1 + (seg * 3) % 7;
      tick_hold = (seg == 3);
      repeat (2500) begin
        cyc();
        for (int k = 0; k < 2; k++) begin
          valid[k] = 1'($urandom_range(0, 1));
          data[k]  = 8'($urandom);
        end
        reset = ($urandom_range(0, 599) == 0);
      end
    end
    reset = 1'b0; valid = '0;
    repeat (5) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
